// File: rtl/rgb_pwm_fader.sv
// Multi-channel PWM LED driver with a valid/ready load port, period-boundary duty
// commits and an optional linear fade toward the committed target duty.

module rgb_pwm_fader_lane #(
    parameter int WIDTH     = 8,
    parameter int FADE_STEP = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] cnt,
    input  logic             boundary,
    input  logic             fade,
    input  logic [WIDTH-1:0] target_next,
    input  logic [WIDTH-1:0] target,
    output logic             pwm,
    output logic             differs
);
    localparam logic [WIDTH:0] STEP = (WIDTH+1)'(FADE_STEP);

    logic [WIDTH-1:0] active;
    logic [WIDTH-1:0] faded;
    logic [WIDTH:0]   a_ext;
    logic [WIDTH:0]   t_ext;
    logic [WIDTH:0]   up;
    logic [WIDTH:0]   dn;

    // One extra bit of headroom so the step can never wrap past the target.
    always_comb begin
        a_ext = {1'b0, active};
        t_ext = {1'b0, target_next};
        up    = a_ext + STEP;
        dn    = a_ext - STEP;
        faded = active;
        if (a_ext < t_ext)
            faded = (up > t_ext) ? target_next : up[WIDTH-1:0];
        else if (a_ext > t_ext)
            faded = (a_ext < t_ext + STEP) ? target_next : dn[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            active <= '0;
            pwm    <= 1'b0;
        end else begin
            if (boundary)
                active <= fade ? faded : target_next;
            pwm <= (&active) ? 1'b1 : (cnt < active);
        end
    end

    assign differs = (active != target);
endmodule

module rgb_pwm_fader #(
    parameter int WIDTH     = 8,
    parameter int CHANNELS  = 3,
    parameter int PRESCALE  = 1,
    parameter int FADE_STEP = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] duty_in,
    input  logic                      mode_in,
    input  logic                      load_valid,
    output logic                      load_ready,
    output logic [CHANNELS-1:0]       pwm_out,
    output logic                      period_start,
    output logic                      busy
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    typedef struct packed {
        logic                           mode;
        logic [CHANNELS-1:0][WIDTH-1:0] duty;
    } load_t;

    logic [PW-1:0]       presc_cnt;
    logic [WIDTH-1:0]    cnt;
    logic                tick;
    logic                boundary;
    logic                pending;
    logic                accept;
    logic                commit;
    load_t               staged;
    load_t               committed;
    load_t               nxt;
    logic [CHANNELS-1:0] differs;

    assign tick       = (presc_cnt == PW'(PRESCALE - 1));
    assign boundary   = tick && (&cnt);
    assign load_ready = !pending;
    assign accept     = load_valid && !pending;
    assign commit     = boundary && pending;
    // Lanes see the post-commit view so a new target applies at the same boundary.
    assign nxt        = commit ? staged : committed;

    always_ff @(posedge clk) begin
        if (!rst) begin
            presc_cnt    <= '0;
            cnt          <= '0;
            period_start <= 1'b0;
        end else begin
            presc_cnt    <= tick ? '0 : presc_cnt + 1'b1;
            if (tick)
                cnt <= cnt + 1'b1;
            period_start <= boundary;
        end
    end

    // pending is never set while a commit happens, since accept requires !pending.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pending   <= 1'b0;
            staged    <= '0;
            committed <= '0;
        end else begin
            if (accept) begin
                staged.mode <= mode_in;
                staged.duty <= duty_in;
                pending     <= 1'b1;
            end else if (commit) begin
                pending <= 1'b0;
            end
            if (commit)
                committed <= staged;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        rgb_pwm_fader_lane #(
            .WIDTH     (WIDTH),
            .FADE_STEP (FADE_STEP)
        ) u_lane (
            .clk         (clk),
            .rst         (rst),
            .cnt         (cnt),
            .boundary    (boundary),
            .fade        (nxt.mode),
            .target_next (nxt.duty[i]),
            .target      (committed.duty[i]),
            .pwm         (pwm_out[i]),
            .differs     (differs[i])
        );
    end

    assign busy = pending || (committed.mode && (|differs));
endmodule

// File: tb/tb_rgb_pwm_fader.sv
// Directed bench: three fader configurations (defaults, FADE_STEP=3, PRESCALE=4/WIDTH=4)
// checked by counting PWM high cycles per period against hand-computed duties.

module tb_rgb_pwm_fader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b, rst_c;
    logic [23:0] duty_a;
    logic [7:0]  duty_b;
    logic [3:0]  duty_c;
    logic        mode_a, mode_b, mode_c;
    logic        valid_a, valid_b, valid_c;
    logic        ready_a, ready_b, ready_c;
    logic [2:0]  pwm_a;
    logic        pwm_b, pwm_c;
    logic        ps_a, ps_b, ps_c;
    logic        busy_a, busy_b, busy_c;

    int tests = 0;
    int fails = 0;

    rgb_pwm_fader u_a (
        .clk(clk), .rst(rst_a), .duty_in(duty_a), .mode_in(mode_a), .load_valid(valid_a),
        .load_ready(ready_a), .pwm_out(pwm_a), .period_start(ps_a), .busy(busy_a));

    rgb_pwm_fader #(.WIDTH(8), .CHANNELS(1), .PRESCALE(1), .FADE_STEP(3)) u_b (
        .clk(clk), .rst(rst_b), .duty_in(duty_b), .mode_in(mode_b), .load_valid(valid_b),
        .load_ready(ready_b), .pwm_out(pwm_b), .period_start(ps_b), .busy(busy_b));

    rgb_pwm_fader #(.WIDTH(4), .CHANNELS(1), .PRESCALE(4), .FADE_STEP(1)) u_c (
        .clk(clk), .rst(rst_c), .duty_in(duty_c), .mode_in(mode_c), .load_valid(valid_c),
        .load_ready(ready_c), .pwm_out(pwm_c), .period_start(ps_c), .busy(busy_c));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] get_pwm(input int which);
        case (which)
            0:       return pwm_a;
            1:       return {2'b00, pwm_b};
            default: return {2'b00, pwm_c};
        endcase
    endfunction

    function automatic logic get_ps(input int which);
        case (which)
            0:       return ps_a;
            1:       return ps_b;
            default: return ps_c;
        endcase
    endfunction

    task automatic load(input int which, input logic [23:0] d, input logic m);
        case (which)
            0: begin duty_a = d; mode_a = m; valid_a = 1'b1; end
            1: begin duty_b = d[7:0]; mode_b = m; valid_b = 1'b1; end
            default: begin duty_c = d[3:0]; mode_c = m; valid_c = 1'b1; end
        endcase
        @(negedge clk);
        valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0;
    endtask

    // Aligns to a period_start sample, then counts highs over the next len cycles,
    // which is exactly the period that boundary started (pwm lags cnt by one).
    task automatic measure(input int which, input int len,
                           output int h0, output int h1, output int h2, output int nps);
        int n = 0;
        logic [2:0] p;
        h0 = 0; h1 = 0; h2 = 0; nps = 0;
        while (get_ps(which) !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) check("period_start_timeout", 0, 1);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            p = get_pwm(which);
            h0 += int'(p[0]); h1 += int'(p[1]); h2 += int'(p[2]);
            nps += int'(get_ps(which));
        end
    endtask

    initial begin
        int h0, h1, h2, nps, n, hc;
        rst_a = 0; rst_b = 0; rst_c = 0;
        valid_a = 1; valid_b = 1; valid_c = 1;
        mode_a = 1; mode_b = 1; mode_c = 1;
        duty_a = 24'hFFFFFF; duty_b = 8'hFF; duty_c = 4'hF;
        repeat (3) @(negedge clk);
        check("rst_pwm", 32'(pwm_a), 0);
        check("rst_ps", 32'(ps_a), 0);
        check("rst_busy", 32'(busy_a), 0);
        check("rst_ready", 32'(ready_a), 1);

        rst_a = 1; rst_b = 1; rst_c = 1;
        valid_a = 0; valid_b = 0; valid_c = 0;
        mode_a = 0; mode_b = 0; mode_c = 0;
        @(negedge clk);
        check("idle_busy", 32'(busy_a), 0);
        check("idle_ready", 32'(ready_a), 1);
        measure(0, 256, h0, h1, h2, nps);
        check("idle_nothing_latched", 32'(h0 + h1 + h2), 0);

        // Direct mode R=32 G=0 B=255
        load(0, {8'd255, 8'd0, 8'd32}, 1'b0);
        check("load_ready_low", 32'(ready_a), 0);
        check("load_busy", 32'(busy_a), 1);
        measure(0, 256, h0, h1, h2, nps);
        check("direct_r32", 32'(h0), 32);
        check("direct_g0", 32'(h1), 0);
        check("direct_b255_full", 32'(h2), 256);
        check("period_start_per_256", 32'(nps), 1);
        measure(0, 256, h0, h1, h2, nps);
        check("direct_r32_again", 32'(h0), 32);
        check("direct_busy_idle", 32'(busy_a), 0);

        // Boundary gating: mid-period load, second request ignored
        repeat (50) @(negedge clk);
        load(0, {8'd255, 8'd0, 8'd128}, 1'b0);
        check("gate_ready_low", 32'(ready_a), 0);
        duty_a = {8'd255, 8'd0, 8'd200}; valid_a = 1;
        repeat (3) @(negedge clk);
        check("gate_ready_still_low", 32'(ready_a), 0);
        valid_a = 0;
        repeat (2) @(negedge clk);
        check("gate_no_early_change", 32'(pwm_a[0]), 0);
        measure(0, 256, h0, h1, h2, nps);
        check("gate_r128", 32'(h0), 128);
        check("gate_ready_back", 32'(ready_a), 1);
        measure(0, 256, h0, h1, h2, nps);
        check("gate_second_ignored", 32'(h0), 128);

        // Fade step 1: 0 -> 4
        load(0, 24'd0, 1'b0);
        measure(0, 256, h0, h1, h2, nps);
        check("fade_base_r0", 32'(h0), 0);
        check("fade_base_b0", 32'(h2), 0);
        load(0, {8'd0, 8'd0, 8'd4}, 1'b1);
        check("fade_busy_pending", 32'(busy_a), 1);
        measure(0, 256, h0, h1, h2, nps);
        check("fade_r1", 32'(h0), 1);
        check("fade_busy1", 32'(busy_a), 1);
        measure(0, 256, h0, h1, h2, nps);
        check("fade_r2", 32'(h0), 2);
        check("fade_busy2", 32'(busy_a), 1);
        measure(0, 256, h0, h1, h2, nps);
        check("fade_r3", 32'(h0), 3);
        check("fade_busy_drop", 32'(busy_a), 0);
        measure(0, 256, h0, h1, h2, nps);
        check("fade_r4", 32'(h0), 4);
        check("fade_busy_done", 32'(busy_a), 0);

        // Fade step 3 with clamping
        load(1, 24'd10, 1'b0);
        measure(1, 256, h0, h1, h2, nps);
        check("clamp_base10", 32'(h0), 10);
        load(1, 24'd2, 1'b1);
        measure(1, 256, h0, h1, h2, nps);
        check("clamp_7", 32'(h0), 7);
        check("clamp_busy", 32'(busy_b), 1);
        measure(1, 256, h0, h1, h2, nps);
        check("clamp_4", 32'(h0), 4);
        measure(1, 256, h0, h1, h2, nps);
        check("clamp_2", 32'(h0), 2);
        check("clamp_busy_done", 32'(busy_b), 0);
        measure(1, 256, h0, h1, h2, nps);
        check("clamp_hold_2", 32'(h0), 2);

        load(1, 24'd10, 1'b0);
        measure(1, 256, h0, h1, h2, nps);
        check("retarget_base10", 32'(h0), 10);
        load(1, 24'd2, 1'b1);
        measure(1, 256, h0, h1, h2, nps);
        check("retarget_7", 32'(h0), 7);
        repeat (100) @(negedge clk);
        load(1, 24'd8, 1'b1);
        measure(1, 256, h0, h1, h2, nps);
        check("retarget_up_7", 32'(h0), 7);
        measure(1, 256, h0, h1, h2, nps);
        check("retarget_8", 32'(h0), 8);
        check("retarget_busy_done", 32'(busy_b), 0);

        // Prescaler 4, width 4: duty 5 -> 20 of 64
        load(2, 24'd5, 1'b0);
        measure(2, 64, h0, h1, h2, nps);
        check("presc_high20", 32'(h0), 20);
        check("presc_period64", 32'(nps), 1);
        repeat (8) @(negedge clk);
        check("presc_pre_reset_high", 32'(pwm_c), 1);
        rst_c = 0;
        @(negedge clk);
        check("midrst_pwm", 32'(pwm_c), 0);
        check("midrst_ps", 32'(ps_c), 0);
        check("midrst_busy", 32'(busy_c), 0);
        check("midrst_ready", 32'(ready_c), 1);
        rst_c = 1; duty_c = 4'd5; mode_c = 0; valid_c = 1;
        n = 0; hc = 0;
        do begin
            @(negedge clk);
            valid_c = 0;
            n++;
            hc += int'(pwm_c);
        end while (ps_c !== 1'b1 && n < 200);
        check("restart_first_boundary", 32'(n), 64);
        check("restart_active_cleared", 32'(hc), 0);
        measure(2, 64, h0, h1, h2, nps);
        check("restart_high20", 32'(h0), 20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rgb_pwm_fader.md
Name: rgb_pwm_fader

Overview:
Parametrised multi-channel PWM LED driver, the successor to the fixed 3×8-bit RGB controller. It drives CHANNELS outputs with WIDTH-bit duty resolution and a configurable clock prescaler. It adds a valid/ready load handshake, duty updates that only take effect at period boundaries (no glitches), and an optional linear fade mode. It sits between the board-level colour/sequencer logic and the LED pins.

Parameters:
WIDTH, 8, duty and PWM counter resolution in bits (≥2).
CHANNELS, 3, number of PWM outputs (1..16); channel 0 = red, 1 = green, 2 = blue for RGB use.
PRESCALE, 1, clocks per PWM counter tick (≥1).
FADE_STEP, 1, duty change per channel per PWM period in fade mode (1..2^WIDTH-1).

Ports:
clk  in  1  system clock, all logic on rising edge.
rst  in  1  synchronous reset, active-low; sampled on clk rising edge.
duty_in  in  CHANNELS*WIDTH  target duties; channel i is bits [i*WIDTH +: WIDTH].
mode_in  in  1  0 = direct, 1 = fade; captured with duty_in.
load_valid  in  1  load request.
load_ready  out  1  high when a load can be accepted.
pwm_out  out  CHANNELS  PWM outputs, registered.
period_start  out  1  one-cycle pulse on each PWM period boundary.
busy  out  1  high while a load is pending or any channel is still fading.

Behaviour:
- Reset (rst=0 at a clk edge): prescaler, counter, active duties, committed targets, pending flag, mode = 0; pwm_out=0, period_start=0, busy=0, load_ready=1 on the following cycle. Reset overrides every other event, including mid-fade and mid-handshake.
- Prescaler: presc_cnt counts 0..PRESCALE-1 and wraps. tick = (presc_cnt==PRESCALE-1). When PRESCALE=1, tick is high every cycle.
- PWM counter: cnt (WIDTH bits) increments on tick and wraps 2^WIDTH-1 → 0. Period = PRESCALE·2^WIDTH clocks.
- Boundary: boundary = tick && cnt==2^WIDTH-1. period_start is registered from boundary, so it goes high in the cycle cnt becomes 0.
- Compare: pwm_out[i] <= (active[i]==all-ones) ? 1 : (cnt < active[i]). This adds one cycle of latency from cnt.
  - duty 0 → constant low.
  - duty all-ones → constant high (full-on).
  - any other duty d → high for d·PRESCALE clocks per period.
- Handshake:
  - load_ready = !pending.
  - Accept = load_valid && load_ready. On accept, duty_in and mode_in are latched into the staged registers and pending is set.
  - load_valid while not ready is ignored; the data is not latched.
- Commit (at boundary with pending=1): staged values are copied to the committed targets and mode; pending is cleared, so load_ready rises the next cycle.
- An accept in the same cycle as a boundary is NOT committed at that boundary; it waits for the next one.
- Active duty update, on each boundary, using the mode in effect after commit:
  - Direct: active[i] <= committed[i].
  - Fade: if active<target, active <= min(active+FADE_STEP, target); if active>target, active <= max(active-FADE_STEP, target). Arithmetic is done at WIDTH+1 bits, with no wrap or overshoot.
- A new load committed mid-fade retargets from the current active value. Fade does not restart from the old target.
- Active duties never change except at a boundary, so no partial-period glitches.
- busy = pending || (mode==fade && any active[i]≠committed[i]). It is combinational from registers.

Test Plan:
- Reset/idle: hold rst=0 for 3 cycles with load_valid=1 → pwm_out=0, period_start=0, busy=0, load_ready=1 after release; nothing is latched.
- Direct duty (defaults, PRESCALE=1): load R=32, G=0, B=255 in direct mode → after the next boundary, pwm_out[0] is high 32 of every 256 cycles, pwm_out[1] is constant 0, pwm_out[2] is constant 1; period_start pulses every 256 cycles.
- Boundary gating: load 128 mid-period, then assert load_valid again → load_ready=0 until the boundary, the second request is ignored, and the duty changes only at the start of the next period.
- Fade (FADE_STEP=1): direct-load 0, then fade-load R=4 → R active = 1, 2, 3, 4 over the next four periods; busy is high until the boundary where R reaches 4, and then drops.
- Fade clamp (FADE_STEP=3): active 10 → target 2 gives 7, 4, 2 with no underflow; retarget to 8 at active 4 gives 7, then 8.
- Prescaler (PRESCALE=4, WIDTH=4): duty 5 → high 20 of every 64 clocks; assert rst=0 mid-period → outputs 0 on the next cycle and counters restart from 0.
